match_tracker: RTL
==================

Name: match_tracker

Overview:
Sequential, parametrised match referee for the two-player game datapath. It accepts one round result per handshake and keeps registered round, P1-win and P2-win counts. It declares the match finished either when all ROUNDS rounds have been played or early, once the trailing player can no longer catch up. It latches the winner code and holds it for the display/FSM logic until the next start.

Parameters:
ROUNDS, 9, rounds in a full match (1..15); early-finish rule uses ROUNDS.
CW, 4, counter width; must satisfy 2^CW > ROUNDS.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
start  in  1  begin new match; clears counts, enters PLAY (accepted in any state)
result_valid  in  1  round result present this cycle
result  in  2  01 = P1 wins round, 10 = P2 wins round, 11 = drawn round, 00 = invalid (ignored)
round  out  CW  rounds played in current match
win  out  CW  rounds won by P1
lose  out  CW  rounds won by P2 (rounds lost by P1)
busy  out  1  high in PLAY
fin  out  1  match finished; high in DONE
printwinner  out  2  00 = not finished, 10 = P1 wins, 11 = P2 wins, 01 = draw; valid only while fin=1
done_pulse  out  1  one-cycle pulse on the first cycle fin=1

Behaviour:
- States: IDLE, PLAY, DONE. Reset -> IDLE. All outputs are 0 in reset and IDLE: round, win, lose, busy, fin, printwinner, done_pulse.
- IDLE: start -> PLAY with counts 0. result_valid is ignored.
- PLAY: a round is accepted when result_valid=1, result!=00 and start=0.
  - On the accepting edge, round+1 and the matching counter +1. A drawn round increments round only.
  - result=00 with result_valid=1: no change.
- Finish check uses the post-update values r', w', l', computed in CW+1 bits with no wrap:
  - P1 decided: w' > l' + (ROUNDS - r').
  - P2 decided: l' > w' + (ROUNDS - r').
  - Full match: r' == ROUNDS.
- If any finish condition holds, on the same edge that updates the counts:
  - state -> DONE, fin=1.
  - printwinner = 10 if w'>l', 11 if l'>w', else 01.
  - done_pulse=1 for exactly that one cycle.
- Latency: counts, fin and printwinner all become visible one cycle after the accepting edge. No combinational path runs from inputs to outputs.
- DONE: counts, fin and printwinner hold. result_valid is ignored. start -> PLAY with counts cleared, fin=0 and printwinner=00 on the next edge.
- start in PLAY (mid-match): restart. Counts clear to 0, stay in PLAY, and any simultaneous result is discarded. start has priority over result_valid in every state.
- reset has priority over start and result_valid. Reset mid-match returns to IDLE with all counts 0 on the next edge.
- Counters never exceed ROUNDS, because DONE is entered at r'==ROUNDS at the latest. No wrap-around is possible for legal parameters.
- done_pulse must not re-fire while the block holds in DONE.

Test Plan:
- ROUNDS=9: reset, start, five accepted P1 wins (01) on consecutive cycles. After the 4th, fin=0 (4 > 0+5 fails). After the 5th: round=5, win=5, lose=0, fin=1, printwinner=10, done_pulse high for exactly one cycle.
- ROUNDS=9: P1,P2 alternating 8 times, then draw (11). After the 8th, fin=0 with win=4, lose=4. After the draw: round=9, fin=1, printwinner=01.
- ROUNDS=9: P2 wins 3, P1 wins 1, P2 wins 2 -> fin=1 after 6th round (5 > 1+3), printwinner=11, lose=5, win=1. Further result_valid pulses in DONE leave all outputs unchanged.
- Hold result_valid=1 with result=00 for 10 cycles in PLAY -> round stays 0, fin=0. Assert start together with result=01 mid-match -> counts 0, result discarded, busy=1.
- Reset asserted mid-match (round=3) -> next edge: IDLE, all outputs 0. result_valid in IDLE has no effect until start.
- ROUNDS=3, CW=2: P1, P1 -> fin after 2nd round (2 > 0+1), printwinner=10. start -> fin=0, printwinner=00, round=0 next cycle.

Source files
------------

// File: rtl/match_tracker.sv
// Match referee: counts rounds and wins per player, declares the winner on full or decided match.
// Latency: counts, fin and printwinner update one cycle after the accepting edge; all outputs registered.
// Backpressure: none; one result per cycle is absorbed, results outside PLAY are dropped.
module match_tracker #(
    parameter int ROUNDS = 9,
    parameter int CW     = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          result_valid,
    input  logic [1:0]    result,
    output logic [CW-1:0] round,
    output logic [CW-1:0] win,
    output logic [CW-1:0] lose,
    output logic          busy,
    output logic          fin,
    output logic [1:0]    printwinner,
    output logic          done_pulse
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        DONE = 2'd2
    } state_t;

    // One extra bit so the "can still catch up" arithmetic never wraps.
    localparam logic [CW:0] ROUNDS_W = (CW+1)'(ROUNDS);

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] round_nxt;
    logic [CW-1:0] win_nxt;
    logic [CW-1:0] lose_nxt;
    logic [1:0]    pw_nxt;
    logic          dp_nxt;

    logic          accept;
    logic [CW:0]   r_w;
    logic [CW:0]   w_w;
    logic [CW:0]   l_w;
    logic [CW:0]   left_w;
    logic          p1_dec;
    logic          p2_dec;
    logic          full;

    // Status flags are pure state decodes, so they stay registered.
    assign busy = (state == PLAY);
    assign fin  = (state == DONE);

    // Next-state and next-count logic; start always overrides a same-cycle result.
    always_comb begin
        state_nxt = state;
        round_nxt = round;
        win_nxt   = win;
        lose_nxt  = lose;
        pw_nxt    = printwinner;
        dp_nxt    = 1'b0;

        accept = (state == PLAY) && result_valid && (result != 2'b00) && !start;
        r_w    = {1'b0, round} + (CW+1)'(accept);
        w_w    = {1'b0, win}   + (CW+1)'(accept && (result == 2'b01));
        l_w    = {1'b0, lose}  + (CW+1)'(accept && (result == 2'b10));
        left_w = ROUNDS_W - r_w;
        p1_dec = w_w > (l_w + left_w);
        p2_dec = l_w > (w_w + left_w);
        full   = (r_w == ROUNDS_W);

        if (start) begin
            state_nxt = PLAY;
            round_nxt = '0;
            win_nxt   = '0;
            lose_nxt  = '0;
            pw_nxt    = 2'b00;
        end else if (accept) begin
            round_nxt = r_w[CW-1:0];
            win_nxt   = w_w[CW-1:0];
            lose_nxt  = l_w[CW-1:0];
            if (p1_dec || p2_dec || full) begin
                state_nxt = DONE;
                dp_nxt    = 1'b1;
                if (w_w > l_w) begin
                    pw_nxt = 2'b10;
                end else if (l_w > w_w) begin
                    pw_nxt = 2'b11;
                end else begin
                    pw_nxt = 2'b01;
                end
            end
        end
    end

    // State and count registers; reset dominates everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            round       <= '0;
            win         <= '0;
            lose        <= '0;
            printwinner <= 2'b00;
            done_pulse  <= 1'b0;
        end else begin
            state       <= state_nxt;
            round       <= round_nxt;
            win         <= win_nxt;
            lose        <= lose_nxt;
            printwinner <= pw_nxt;
            done_pulse  <= dp_nxt;
        end
    end

endmodule
